// File: rtl/tlb_pkg.sv
// tlb_pkg: entry layout, op codes and kseg bypass constants shared by the TLB files
package tlb_pkg;
   localparam int TLB_ASID_W = 8;
   localparam int TLB_PFN_W = 24;
   localparam logic [1:0] KSEG_SEL = 2'b10;
   localparam logic [2:0] KSEG_PAD = 3'b000;
   typedef enum logic [1:0] {
      TLBWI = 2'd0,
      TLBWR = 2'd1,
      TLBR  = 2'd2,
      TLBP  = 2'd3
   } tlb_op_e;
   typedef struct packed {
      logic [18:0]           vpn2;
      logic [TLB_ASID_W-1:0] asid;
      logic                  g;
      logic [TLB_PFN_W-1:0]  pfn1;
      logic                  d1;
      logic                  v1;
      logic [TLB_PFN_W-1:0]  pfn0;
      logic                  d0;
      logic                  v0;
   } tlb_entry_t;
   function automatic logic entryMatch(input tlb_entry_t e, input logic [18:0] vpn2, input logic [TLB_ASID_W-1:0] asid);
      return (e.vpn2 == vpn2) && (e.g || e.asid == asid);
   endfunction
endpackage

// File: rtl/tlb_lookup.sv
// tlb_lookup: combinational match and even/odd page select for one translation port
module tlb_lookup
   import tlb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int PFN_W = TLB_PFN_W
)(
   input  tlb_entry_t [ENTRIES-1:0] tlb,
   input  logic [31:0]              vaddr,
   input  logic [TLB_ASID_W-1:0]    curAsid,
   output logic [31:0]              paddr,
   output logic                     miss,
   output logic                     invalid,
   output logic                     dirty
);
   localparam int IW = $clog2(ENTRIES);
   logic hit, odd, v, d, bypass;
   logic [IW-1:0] sel;
   logic [PFN_W-1:0] pfn;
   logic [PFN_W-21:0] unusedPfnHi;
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = ENTRIES-1; i >= 0; i--)
         if (entryMatch(tlb[i], vaddr[31:13], curAsid)) begin
            hit = 1'b1;
            sel = i[IW-1:0];
         end
   end
   assign odd = vaddr[12];
   assign pfn = odd ? tlb[sel].pfn1 : tlb[sel].pfn0;
   assign v = odd ? tlb[sel].v1 : tlb[sel].v0;
   assign d = odd ? tlb[sel].d1 : tlb[sel].d0;
   // only the low 20 PFN bits fit a 32-bit physical address
   assign unusedPfnHi = pfn[PFN_W-1:20];
   assign bypass = vaddr[31:30] == KSEG_SEL;
   assign paddr = bypass ? {KSEG_PAD, vaddr[28:0]} : hit ? {pfn[19:0], vaddr[11:0]} : 32'h0;
   assign miss = !bypass && !hit;
   assign invalid = !bypass && hit && !v;
   assign dirty = bypass || (hit && d);
endmodule

// File: rtl/tlb_asid.sv
// tlb_asid: ASID-tagged joint TLB with registered multi-port lookup and a two-cycle maintenance op FSM
module tlb_asid
   import tlb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int PORTS = 2,
   parameter int ASID_W = TLB_ASID_W,
   parameter int PFN_W = TLB_PFN_W
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         op_valid,
   output logic                         op_ready,
   input  logic [1:0]                   op_code,
   input  logic [$clog2(ENTRIES)-1:0]   op_index,
   input  tlb_entry_t                   op_entry,
   input  logic [ASID_W-1:0]            cur_asid,
   input  logic [$clog2(ENTRIES)-1:0]   wired,
   output logic                         op_done,
   output tlb_entry_t                   rd_entry,
   output logic [$clog2(ENTRIES)-1:0]   probe_index,
   output logic                         probe_miss,
   input  logic [PORTS-1:0][31:0]       lk_vaddr,
   output logic [PORTS-1:0][31:0]       lk_paddr,
   output logic [PORTS-1:0]             lk_miss,
   output logic [PORTS-1:0]             lk_invalid,
   output logic [PORTS-1:0]             lk_dirty
);
   localparam int IW = $clog2(ENTRIES);
   localparam logic [IW-1:0] TOP_IDX = IW'(ENTRIES-1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EXEC = 1'b1;
   logic [0:0] state;
   tlb_entry_t [ENTRIES-1:0] tlb;
   tlb_entry_t opEntry;
   logic [IW-1:0] opIdx, random, wiredQ, pIdx;
   logic opWrite, pHit, accept;
   logic [PORTS-1:0][31:0] paddrC;
   logic [PORTS-1:0] missC, invalidC, dirtyC;
   assign op_ready = state == IDLE;
   assign op_done = state == EXEC;
   assign accept = op_ready && op_valid;
   always_comb begin
      pHit = 1'b0;
      pIdx = '0;
      for (int i = ENTRIES-1; i >= 0; i--)
         if (entryMatch(tlb[i], op_entry.vpn2, cur_asid)) begin
            pHit = 1'b1;
            pIdx = i[IW-1:0];
         end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         tlb <= '0;
         opEntry <= '0;
         opIdx <= '0;
         opWrite <= 1'b0;
         random <= TOP_IDX;
         wiredQ <= '0;
         rd_entry <= '0;
         probe_index <= '0;
         probe_miss <= 1'b0;
         lk_paddr <= '0;
         lk_miss <= '0;
         lk_invalid <= '0;
         lk_dirty <= '0;
      end else begin
         state <= accept ? EXEC : IDLE;
         wiredQ <= wired;
         // a wired change restarts the random window from the top
         random <= (wired != wiredQ || random <= wired) ? TOP_IDX : random - IW'(1);
         if (accept) begin
            opWrite <= op_code == TLBWI || op_code == TLBWR;
            opIdx <= (op_code == TLBWR) ? random : op_index;
            opEntry <= op_entry;
         end
         if (accept && op_code == TLBR) rd_entry <= tlb[op_index];
         if (accept && op_code == TLBP) begin
            probe_index <= pIdx;
            probe_miss <= !pHit;
         end
         if (op_done && opWrite) tlb[opIdx] <= opEntry;
         lk_paddr <= paddrC;
         lk_miss <= missC;
         lk_invalid <= invalidC;
         lk_dirty <= dirtyC;
      end
   for (genvar p = 0; p < PORTS; p++) begin : gPort
      tlb_lookup #(.ENTRIES(ENTRIES), .PFN_W(PFN_W)) uLookup (
         .tlb(tlb),
         .vaddr(lk_vaddr[p]),
         .curAsid(cur_asid),
         .paddr(paddrC[p]),
         .miss(missC[p]),
         .invalid(invalidC[p]),
         .dirty(dirtyC[p])
      );
   end
endmodule

// File: tb/tb_tlb_asid.sv
// tb_tlb_asid: directed self-checking bench for tlb_asid with default parameters
module tb_tlb_asid;
   import tlb_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic op_valid = 1'b0;
   logic op_ready;
   logic [1:0] op_code = 2'd0;
   logic [3:0] op_index = 4'd0;
   tlb_entry_t op_entry = '0;
   logic [7:0] cur_asid = 8'd0;
   logic [3:0] wired = 4'd0;
   logic op_done;
   tlb_entry_t rd_entry;
   logic [3:0] probe_index;
   logic probe_miss;
   logic [1:0][31:0] lk_vaddr = {32'h00400000, 32'h00400000};
   logic [1:0][31:0] lk_paddr;
   logic [1:0] lk_miss, lk_invalid, lk_dirty;
   int checks = 0;
   int passes = 0;
   tlb_entry_t eWi, eA, eB, eC, eD, eE, eF, eG, eH, eX;

   tlb_asid dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .op_index(op_index), .op_entry(op_entry), .cur_asid(cur_asid), .wired(wired),
      .op_done(op_done), .rd_entry(rd_entry), .probe_index(probe_index), .probe_miss(probe_miss),
      .lk_vaddr(lk_vaddr), .lk_paddr(lk_paddr), .lk_miss(lk_miss), .lk_invalid(lk_invalid),
      .lk_dirty(lk_dirty)
   );

   always #5 clk = ~clk;

   function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                     input logic [23:0] pfn0, input logic d0, input logic v0,
                                     input logic [23:0] pfn1, input logic d1, input logic v1);
      tlb_entry_t e;
      e.vpn2 = vpn2; e.asid = asid; e.g = g; e.pfn0 = pfn0; e.d0 = d0; e.v0 = v0;
      e.pfn1 = pfn1; e.d1 = d1; e.v1 = v1;
      return e;
   endfunction

   task automatic doOp(input logic [1:0] code, input logic [3:0] idx, input tlb_entry_t e, output logic done);
      op_valid = 1'b1; op_code = code; op_index = idx; op_entry = e;
      @(posedge clk); @(negedge clk);
      op_valid = 1'b0; done = op_done;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (op_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", op_ready); else passes++;
      checks++; if (op_done !== 1'b0) $display("FAIL rst_done got %b want 0", op_done); else passes++;
      checks++; if (rd_entry !== '0) $display("FAIL rst_rd_entry got %h want 0", rd_entry); else passes++;
      checks++; if ({probe_index, probe_miss} !== 5'd0) $display("FAIL rst_probe got %h/%b want 0/0", probe_index, probe_miss); else passes++;
      checks++; if (lk_paddr !== 64'd0) $display("FAIL rst_paddr got %h want 0", lk_paddr); else passes++;
      checks++; if ({lk_miss, lk_invalid, lk_dirty} !== 6'd0) $display("FAIL rst_flags got %b want 000000", {lk_miss, lk_invalid, lk_dirty}); else passes++;
      @(negedge clk);
   endtask

   task automatic test_miss;
      lk_vaddr = {32'h00400000, 32'h00400000};
      @(negedge clk);
      checks++; if (lk_miss !== 2'b11) $display("FAIL miss_both got %b want 11", lk_miss); else passes++;
      checks++; if ({lk_paddr, lk_invalid, lk_dirty} !== 68'd0) $display("FAIL miss_outputs got %h want 0", {lk_paddr, lk_invalid, lk_dirty}); else passes++;
   endtask

   task automatic test_wi;
      cur_asid = 8'd5;
      eWi = mk(19'h00200, 8'd5, 1'b0, 24'h000123, 1'b0, 1'b1, 24'hF45678, 1'b1, 1'b0);
      op_valid = 1'b1; op_code = TLBWI; op_index = 4'd3; op_entry = eWi;
      lk_vaddr[0] = 32'h00400ABC; lk_vaddr[1] = 32'h00401ABC;
      @(posedge clk); @(negedge clk);
      op_valid = 1'b0;
      checks++; if ({op_done, op_ready} !== 2'b10) $display("FAIL wi_exec got done/ready %b want 10", {op_done, op_ready}); else passes++;
      @(posedge clk); @(negedge clk);
      checks++; if (lk_miss !== 2'b11) $display("FAIL wi_prewrite got %b want 11", lk_miss); else passes++;
      @(posedge clk); @(negedge clk);
      checks++; if (lk_paddr[0] !== 32'h00123ABC) $display("FAIL wi_even_paddr got %h want 00123abc", lk_paddr[0]); else passes++;
      checks++; if (lk_paddr[1] !== 32'h45678ABC) $display("FAIL wi_odd_paddr got %h want 45678abc", lk_paddr[1]); else passes++;
      checks++; if (lk_miss !== 2'b00) $display("FAIL wi_hit got %b want 00", lk_miss); else passes++;
      checks++; if (lk_invalid !== 2'b10) $display("FAIL wi_invalid got %b want 10", lk_invalid); else passes++;
      checks++; if (lk_dirty !== 2'b10) $display("FAIL wi_dirty got %b want 10", lk_dirty); else passes++;
      cur_asid = 8'd6;
      @(negedge clk);
      checks++; if (lk_miss !== 2'b11) $display("FAIL wi_asid_miss got %b want 11", lk_miss); else passes++;
      checks++; if (lk_paddr !== 64'd0) $display("FAIL wi_asid_paddr got %h want 0", lk_paddr); else passes++;
      cur_asid = 8'd5;
   endtask

   task automatic test_bypass;
      lk_vaddr[0] = 32'h80001234; lk_vaddr[1] = 32'hA0001234;
      @(negedge clk);
      checks++; if (lk_paddr !== {32'h00001234, 32'h00001234}) $display("FAIL byp_paddr got %h want 0000123400001234", lk_paddr); else passes++;
      checks++; if ({lk_miss, lk_invalid, lk_dirty} !== 6'b000011) $display("FAIL byp_flags got %b want 000011", {lk_miss, lk_invalid, lk_dirty}); else passes++;
      lk_vaddr[0] = 32'h9FFFFFFF; lk_vaddr[1] = 32'hC0400ABC;
      @(negedge clk);
      checks++; if (lk_paddr[0] !== 32'h1FFFFFFF) $display("FAIL byp_top got %h want 1fffffff", lk_paddr[0]); else passes++;
      checks++; if ({lk_miss, lk_dirty} !== 4'b1001) $display("FAIL byp_kseg2 got %b want 1001", {lk_miss, lk_dirty}); else passes++;
   endtask

   task automatic test_random;
      logic d;
      eA = mk(19'h03001, 8'd5, 1'b0, 24'h0000A1, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
      eB = mk(19'h03002, 8'd5, 1'b0, 24'h0000B2, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
      eC = mk(19'h03003, 8'd5, 1'b0, 24'h0000C3, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
      eD = mk(19'h03004, 8'd5, 1'b0, 24'h0000D4, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
      eE = mk(19'h03005, 8'd5, 1'b0, 24'h0000E5, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
      eF = mk(19'h03006, 8'd5, 1'b0, 24'h0000F6, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
      wired = 4'd12;
      @(negedge clk);
      doOp(TLBWR, 4'd0, eA, d);
      doOp(TLBWR, 4'd0, eB, d);
      @(negedge clk);
      doOp(TLBWR, 4'd0, eC, d);
      doOp(TLBWR, 4'd0, eD, d);
      doOp(TLBR, 4'd15, '0, d);
      checks++; if (d !== 1'b1 || rd_entry !== eA) $display("FAIL rnd_15 got done %b entry %h want 1 %h", d, rd_entry, eA); else passes++;
      doOp(TLBR, 4'd14, '0, d);
      checks++; if (rd_entry !== eC) $display("FAIL rnd_14 got %h want %h", rd_entry, eC); else passes++;
      doOp(TLBR, 4'd13, '0, d);
      checks++; if (rd_entry !== eB) $display("FAIL rnd_13 got %h want %h", rd_entry, eB); else passes++;
      doOp(TLBR, 4'd12, '0, d);
      checks++; if (rd_entry !== eD) $display("FAIL rnd_12 got %h want %h", rd_entry, eD); else passes++;
      doOp(TLBR, 4'd11, '0, d);
      checks++; if (rd_entry !== '0) $display("FAIL rnd_11 got %h want 0", rd_entry); else passes++;
      wired = 4'd15;
      @(negedge clk);
      doOp(TLBWR, 4'd0, eE, d);
      @(negedge clk);
      doOp(TLBWR, 4'd0, eF, d);
      doOp(TLBR, 4'd15, '0, d);
      checks++; if (rd_entry !== eF) $display("FAIL rnd_held15 got %h want %h", rd_entry, eF); else passes++;
      doOp(TLBR, 4'd14, '0, d);
      checks++; if (rd_entry !== eC) $display("FAIL rnd_keep14 got %h want %h", rd_entry, eC); else passes++;
   endtask

   task automatic test_probe;
      logic d;
      eG = mk(19'h01234, 8'h77, 1'b1, 24'h000222, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
      eH = mk(19'h01234, 8'h77, 1'b1, 24'h000999, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
      cur_asid = 8'd5;
      doOp(TLBWI, 4'd9, eH, d);
      doOp(TLBWI, 4'd2, eG, d);
      lk_vaddr[0] = 32'h02468000;
      doOp(TLBP, 4'd0, mk(19'h01234, 8'd0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0), d);
      checks++; if ({d, probe_index, probe_miss} !== {1'b1, 4'd2, 1'b0}) $display("FAIL probe_low got done %b idx %0d miss %b want 1 2 0", d, probe_index, probe_miss); else passes++;
      checks++; if (lk_paddr[0] !== 32'h00222000 || lk_dirty[0] !== 1'b1) $display("FAIL lookup_low got %h/%b want 00222000/1", lk_paddr[0], lk_dirty[0]); else passes++;
      doOp(TLBP, 4'd0, mk(19'h07777, 8'd0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0), d);
      checks++; if ({probe_index, probe_miss} !== {4'd0, 1'b1}) $display("FAIL probe_none got idx %0d miss %b want 0 1", probe_index, probe_miss); else passes++;
      cur_asid = 8'd6;
      doOp(TLBP, 4'd0, mk(19'h00200, 8'd0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0), d);
      checks++; if (probe_miss !== 1'b1) $display("FAIL probe_asid got miss %b want 1", probe_miss); else passes++;
      cur_asid = 8'd5;
      doOp(TLBP, 4'd0, mk(19'h00200, 8'd0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0), d);
      checks++; if ({probe_index, probe_miss} !== {4'd3, 1'b0}) $display("FAIL probe_idx3 got idx %0d miss %b want 3 0", probe_index, probe_miss); else passes++;
   endtask

   task automatic test_back_to_back;
      op_valid = 1'b1; op_code = TLBR; op_index = 4'd2;
      @(posedge clk); @(negedge clk);
      checks++; if ({op_done, op_ready} !== 2'b10 || rd_entry !== eG) $display("FAIL b2b_first got %b %h want 10 %h", {op_done, op_ready}, rd_entry, eG); else passes++;
      op_index = 4'd9;
      @(posedge clk); @(negedge clk);
      checks++; if ({op_done, op_ready} !== 2'b01 || rd_entry !== eG) $display("FAIL b2b_gap got %b %h want 01 %h", {op_done, op_ready}, rd_entry, eG); else passes++;
      op_index = 4'd3;
      @(posedge clk); @(negedge clk);
      checks++; if ({op_done, op_ready} !== 2'b10 || rd_entry !== eWi) $display("FAIL b2b_second got %b %h want 10 %h", {op_done, op_ready}, rd_entry, eWi); else passes++;
      op_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      logic d;
      eX = mk(19'h05555, 8'd5, 1'b0, 24'h000555, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
      cur_asid = 8'd5;
      lk_vaddr[0] = 32'h0AAAA000;
      op_valid = 1'b1; op_code = TLBWI; op_index = 4'd5; op_entry = eX;
      @(posedge clk); @(negedge clk);
      op_valid = 1'b0;
      checks++; if (op_done !== 1'b1) $display("FAIL abort_exec got done %b want 1", op_done); else passes++;
      #1 rst = 1'b1;
      #1;
      checks++; if ({op_done, op_ready} !== 2'b01) $display("FAIL abort_rst got %b want 01", {op_done, op_ready}); else passes++;
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if ({op_done, op_ready} !== 2'b01) $display("FAIL abort_after got %b want 01", {op_done, op_ready}); else passes++;
      checks++; if (lk_miss[0] !== 1'b1) $display("FAIL abort_lookup got miss %b want 1", lk_miss[0]); else passes++;
      doOp(TLBP, 4'd0, eX, d);
      checks++; if (probe_miss !== 1'b1) $display("FAIL abort_probe got miss %b want 1", probe_miss); else passes++;
      doOp(TLBR, 4'd5, '0, d);
      checks++; if (rd_entry !== '0) $display("FAIL abort_entry got %h want 0", rd_entry); else passes++;
   endtask

   initial begin
      test_reset;
      test_miss;
      test_wi;
      test_bypass;
      test_random;
      test_probe;
      test_back_to_back;
      test_reset_abort;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout passed %0d of %0d", passes, checks);
      $fatal(1);
   end
endmodule
